cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between N_REQ functional units (ALU, FPU, load unit, branch unit, ...).
- Each requester has a one-entry holding slot. A round-robin arbiter drains one slot per cycle onto a registered CDB.
- The CDB feeds the reorder buffer's cdb_valid/cdb inputs and the reservation stations.
- The ROB-clear signal from the branch unit flushes all in-flight results.

---
 rtl/cdb_arbiter.sv | 140 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the single common data bus (CDB) between N_REQ functional units.
//   Each unit owns a one-entry holding slot; a round-robin arbiter drains one
//   slot per cycle onto the registered CDB, which feeds the ROB and the
//   reservation stations. flush (ROB clear) drops every pending result.
//
//   Optional build macro: CDB_ARB_STATS_EN adds saturating per-unit
//   grant/stall counters (grant_cnt, stall_cnt).
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req_valid   per-unit result valid
//   req_ready   per-unit result accepted (slot empty or draining this cycle)
//   req_rsv_id  per-unit ROB id, unit i at [i*RSV_ID_W +: RSV_ID_W]
//   req_data    per-unit result, unit i at [i*DATA_W +: DATA_W]
//   flush       ROB clear; empties all slots, no accept that cycle
//   cdb_valid   registered broadcast valid, one cycle per result
//   cdb         {rsv_id, data}
//   cdb_src     index of the unit owning the current broadcast
//   grant_cnt   (CDB_ARB_STATS_EN) broadcasts per unit, 16 bits each
//   stall_cnt   (CDB_ARB_STATS_EN) cycles valid && !ready per unit
module cdb_arbiter #(
  parameter int N_REQ    = 4,
  parameter int RSV_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int SRC_W    = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*RSV_ID_W-1:0]    req_rsv_id,
  input  logic [N_REQ*DATA_W-1:0]      req_data,
  input  logic                         flush,
  output logic                         cdb_valid,
  output logic [RSV_ID_W+DATA_W-1:0]   cdb,
  output logic [SRC_W-1:0]             cdb_src
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]          grant_cnt,
  output logic [N_REQ*16-1:0]          stall_cnt
`endif
);

  logic [N_REQ-1:0]    slot_valid_p0;
  logic [RSV_ID_W-1:0] slot_id_p0   [N_REQ];
  logic [DATA_W-1:0]   slot_data_p0 [N_REQ];
  logic [SRC_W-1:0]    rr_ptr;

  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    accept;
  logic                found;
  logic [SRC_W-1:0]    win;
  logic [SRC_W-1:0]    rr_nxt;
  logic [SRC_W-1:0]    idx_s;
  int                  idx;

  // Round-robin search from rr_ptr upward, wrapping; only slots already
  // valid this cycle compete, so a result loaded at this edge waits a cycle.
  always_comb begin
    found = 1'b0;
    win   = '0;
    grant = '0;
    idx   = 0;
    idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_s = SRC_W'(idx);
      if (!found && slot_valid_p0[idx_s]) begin
        found = 1'b1;
        win   = idx_s;
      end
    end
    if (found) grant[win] = 1'b1;
  end

  assign rr_nxt = (win == SRC_W'(N_REQ - 1)) ? '0 : win + 1'b1;

  // A slot being drained this cycle can take its next result at the same edge.
  assign req_ready = (rst || flush) ? '0 : (~slot_valid_p0 | grant);
  assign accept    = req_valid & req_ready;

  // Slot stage -> CDB stage
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_p0 <= '0;
      rr_ptr        <= '0;
      cdb_valid     <= 1'b0;
      cdb           <= '0;
      cdb_src       <= '0;
    end else if (flush) begin
      slot_valid_p0 <= '0;
      rr_ptr        <= '0;
      cdb_valid     <= 1'b0;
    end else begin
      slot_valid_p0 <= (slot_valid_p0 & ~grant) | accept;
      if (found) begin
        cdb_valid <= 1'b1;
        cdb       <= {slot_id_p0[win], slot_data_p0[win]};
        cdb_src   <= win;
        rr_ptr    <= rr_nxt;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

  // Input -> slot stage
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_id_p0[i]   <= req_rsv_id[i*RSV_ID_W +: RSV_ID_W];
        slot_data_p0[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Statistics stage; flush deliberately leaves the counts intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && !flush)
          grant_cnt[i*16 +: 16] <= sat_inc(grant_cnt[i*16 +: 16]);
        if (req_valid[i] && !req_ready[i])
          stall_cnt[i*16 +: 16] <= sat_inc(stall_cnt[i*16 +: 16]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter (N_REQ=4, RSV_ID_W=4, DATA_W=32).
//   Inputs change 2 time units after each rising edge; outputs are sampled
//   one unit later, well away from the next edge.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [15:0]  req_rsv_id;
  logic [127:0] req_data;
  logic         cdb_valid;
  logic [35:0]  cdb;
  logic [1:0]   cdb_src;
`ifdef CDB_ARB_STATS_EN
  logic [63:0]  grant_cnt;
  logic [63:0]  stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int seq [4];
  int bc  [4];
  int s;
  logic [3:0]  acc;
  logic [35:0] hold;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rsv_id (req_rsv_id),
    .req_data   (req_data),
    .flush      (flush),
    .cdb_valid  (cdb_valid),
    .cdb        (cdb),
    .cdb_src    (cdb_src)
`ifdef CDB_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [3:0] id, input logic [31:0] d);
    req_valid[i]          = 1'b1;
    req_rsv_id[i*4 +: 4]  = id;
    req_data[i*32 +: 32]  = d;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = '0;
    req_rsv_id = '0;
    req_data   = '0;

    // Reset state
    step();
    step();
    req_valid = 4'hF;
    #1;
    check("rst_ready", 64'(req_ready), 64'(4'h0));
    check("rst_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    check("rst_cdb", 64'(cdb), 64'(36'h0));
    check("rst_cdb_src", 64'(cdb_src), 64'(2'd0));
`ifdef CDB_ARB_STATS_EN
    check("rst_grant_cnt", grant_cnt, 64'h0);
`endif
    req_valid = '0;
    rst = 1'b0;
    step();

    // Single request from unit 2
    set_req(2, 4'h5, 32'hDEAD_BEEF);
    #1;
    check("single_ready", 64'(req_ready[2]), 64'(1'b1));
    step();
    req_valid = '0;
    #1;
    check("single_lat_valid", 64'(cdb_valid), 64'(1'b0));
    step();
    #1;
    check("single_valid", 64'(cdb_valid), 64'(1'b1));
    check("single_cdb", 64'(cdb), 64'({4'h5, 32'hDEAD_BEEF}));
    check("single_src", 64'(cdb_src), 64'(2'd2));
    step();
    #1;
    check("single_done", 64'(cdb_valid), 64'(1'b0));

    // Flush to bring rr_ptr back to 0, then all four units continuously
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      bc[i]  = 0;
      set_req(i, 4'(i), {16'(i), 16'(0)});
    end
    #1;
    for (int k = 1; k <= 10; k++) begin
      acc = req_valid & req_ready;
      step();
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          seq[i]++;
          set_req(i, 4'(4 * seq[i] + i), {16'(i), 16'(seq[i])});
        end
      end
      #1;
      check("rr_ready", 64'(req_ready), 64'(4'b0001 << ((k - 1) % 4)));
      if (k >= 2) begin
        s = (k - 2) % 4;
        check("rr_valid", 64'(cdb_valid), 64'(1'b1));
        check("rr_src", 64'(cdb_src), 64'(s));
        check("rr_data", 64'(cdb[31:0]), 64'({16'(s), 16'(bc[s])}));
        bc[s]++;
      end
    end
    req_valid = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("rr_flush_valid", 64'(cdb_valid), 64'(1'b0));

    // Back-to-back from unit 1
    seq[1] = 0;
    set_req(1, 4'h0, 32'h1000_0000);
    #1;
    for (int k = 1; k <= 6; k++) begin
      acc = req_valid & req_ready;
      step();
      if (acc[1]) begin
        seq[1]++;
        set_req(1, 4'(seq[1]), 32'h1000_0000 + 32'(seq[1]));
      end
      #1;
      if (k >= 2) begin
        check("b2b_valid", 64'(cdb_valid), 64'(1'b1));
        check("b2b_id", 64'(cdb[35:32]), 64'(4'(k - 2)));
        check("b2b_src", 64'(cdb_src), 64'(2'd1));
      end
    end
    req_valid = '0;
    step();
    #1;
    check("b2b_last_valid", 64'(cdb_valid), 64'(1'b1));
    check("b2b_last_cdb", 64'(cdb), 64'({4'h5, 32'h1000_0005}));
    step();
    #1;
    check("b2b_idle", 64'(cdb_valid), 64'(1'b0));

    // Wrap-around: rr_ptr=3 with slots 3 and 0 valid
    set_req(2, 4'h2, 32'h2222_2222);
    step();
    req_valid = '0;
    set_req(3, 4'h3, 32'h3333_3333);
    set_req(0, 4'h8, 32'h0000_0000);
    step();
    req_valid = '0;
    #1;
    check("wrap_src_a", 64'(cdb_src), 64'(2'd2));
    step();
    #1;
    check("wrap_valid_b", 64'(cdb_valid), 64'(1'b1));
    check("wrap_src_b", 64'(cdb_src), 64'(2'd3));
    step();
    #1;
    check("wrap_src_c", 64'(cdb_src), 64'(2'd0));
    check("wrap_cdb_c", 64'(cdb), 64'({4'h8, 32'h0000_0000}));
    step();
    #1;
    check("wrap_idle", 64'(cdb_valid), 64'(1'b0));
    set_req(0, 4'h4, 32'h0A0A_0A0A);
    set_req(1, 4'h9, 32'h0B0B_0B0B);
    step();
    req_valid = '0;
    step();
    #1;
    check("wrap_ptr1_src", 64'(cdb_src), 64'(2'd1));
    step();
    #1;
    check("wrap_ptr2_src", 64'(cdb_src), 64'(2'd0));
    hold = {4'h4, 32'h0A0A_0A0A};

    // Flush with slots 0,1,3 full
    set_req(0, 4'hA, 32'hAAAA_0000);
    set_req(1, 4'hB, 32'hBBBB_0000);
    set_req(3, 4'hC, 32'hCCCC_0000);
    step();
    req_valid = '0;
    flush = 1'b1;
    set_req(2, 4'hD, 32'hDDDD_0000);
    #1;
    check("flush_ready", 64'(req_ready), 64'(4'h0));
    step();
    flush = 1'b0;
    req_valid = '0;
    #1;
    check("flush_valid", 64'(cdb_valid), 64'(1'b0));
    check("flush_cdb_hold", 64'(cdb), 64'(hold));
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      check("flush_no_stale", 64'(cdb_valid), 64'(1'b0));
    end
    set_req(3, 4'h7, 32'h7777_7777);
    step();
    req_valid = '0;
    step();
    #1;
    check("flush_new_valid", 64'(cdb_valid), 64'(1'b1));
    check("flush_new_cdb", 64'(cdb), 64'({4'h7, 32'h7777_7777}));
    check("flush_new_src", 64'(cdb_src), 64'(2'd3));

    // Reset mid-traffic with slots 0,1,2 full
    set_req(0, 4'h1, 32'h1111_1111);
    set_req(1, 4'h2, 32'h2222_1111);
    set_req(2, 4'h3, 32'h3333_1111);
    step();
    req_valid = '0;
    rst = 1'b1;
    set_req(3, 4'hE, 32'hEEEE_EEEE);
    #1;
    check("mrst_ready", 64'(req_ready), 64'(4'h0));
    step();
    rst = 1'b0;
    req_valid = '0;
    #1;
    check("mrst_valid", 64'(cdb_valid), 64'(1'b0));
    check("mrst_cdb", 64'(cdb), 64'(36'h0));
    check("mrst_src", 64'(cdb_src), 64'(2'd0));
    for (int k = 0; k < 2; k++) begin
      step();
      #1;
      check("mrst_no_stale", 64'(cdb_valid), 64'(1'b0));
    end
    set_req(1, 4'h6, 32'h6666_6666);
    step();
    req_valid = '0;
    step();
    #1;
    check("mrst_new_valid", 64'(cdb_valid), 64'(1'b1));
    check("mrst_new_cdb", 64'(cdb), 64'({4'h6, 32'h6666_6666}));
    check("mrst_new_src", 64'(cdb_src), 64'(2'd1));
`ifdef CDB_ARB_STATS_EN
    check("stats_grant1", 64'(grant_cnt[31:16]), 64'(16'd1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
